// File: rtl/jtag_pkg.sv
// Shared types for the JTAG shift engine: engine FSM states, the IEEE 1149.1
// TAP state set, its one-hot encoding (tap_core bit order) and the TAP next-state function.
package jtag_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        RESP = 2'd3
    } fsm_e;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_e;

    localparam logic [15:0] TAP_TEST_LOGIC_RESET = 16'h0001;
    localparam logic [15:0] TAP_RUN_TEST_IDLE    = 16'h0002;
    localparam logic [15:0] TAP_SELECT_DR_SCAN   = 16'h0004;
    localparam logic [15:0] TAP_CAPTURE_DR       = 16'h0008;
    localparam logic [15:0] TAP_SHIFT_DR         = 16'h0010;
    localparam logic [15:0] TAP_EXIT1_DR         = 16'h0020;
    localparam logic [15:0] TAP_PAUSE_DR         = 16'h0040;
    localparam logic [15:0] TAP_EXIT2_DR         = 16'h0080;
    localparam logic [15:0] TAP_UPDATE_DR        = 16'h0100;
    localparam logic [15:0] TAP_SELECT_IR_SCAN   = 16'h0200;
    localparam logic [15:0] TAP_CAPTURE_IR       = 16'h0400;
    localparam logic [15:0] TAP_SHIFT_IR         = 16'h0800;
    localparam logic [15:0] TAP_EXIT1_IR         = 16'h1000;
    localparam logic [15:0] TAP_PAUSE_IR         = 16'h2000;
    localparam logic [15:0] TAP_EXIT2_IR         = 16'h4000;
    localparam logic [15:0] TAP_UPDATE_IR        = 16'h8000;

    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            default:          nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [15:0] tap_onehot(input tap_state_e state);
        logic [15:0] oh;
        case (state)
            TEST_LOGIC_RESET: oh = TAP_TEST_LOGIC_RESET;
            RUN_TEST_IDLE:    oh = TAP_RUN_TEST_IDLE;
            SELECT_DR_SCAN:   oh = TAP_SELECT_DR_SCAN;
            CAPTURE_DR:       oh = TAP_CAPTURE_DR;
            SHIFT_DR:         oh = TAP_SHIFT_DR;
            EXIT1_DR:         oh = TAP_EXIT1_DR;
            PAUSE_DR:         oh = TAP_PAUSE_DR;
            EXIT2_DR:         oh = TAP_EXIT2_DR;
            UPDATE_DR:        oh = TAP_UPDATE_DR;
            SELECT_IR_SCAN:   oh = TAP_SELECT_IR_SCAN;
            CAPTURE_IR:       oh = TAP_CAPTURE_IR;
            SHIFT_IR:         oh = TAP_SHIFT_IR;
            EXIT1_IR:         oh = TAP_EXIT1_IR;
            PAUSE_IR:         oh = TAP_PAUSE_IR;
            EXIT2_IR:         oh = TAP_EXIT2_IR;
            default:          oh = TAP_UPDATE_IR;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Mirror of the target's 16-state TAP controller, advanced on each generated TCK rising edge.
// Only compiled when JTAG_TAP_TRACK_EN is defined; otherwise this file contributes no logic.
`ifdef JTAG_TAP_TRACK_EN
module jtag_tap_tracker
    import jtag_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    input  logic        tms,
    input  logic        trst_n,
    output logic [15:0] tap_state
);

    tap_state_e r_state;
    tap_state_e w_state_nx;

    // trst_n low at a TCK rising edge forces reset, matching a TAP with TRST wired in
    always_comb begin
        w_state_nx = r_state;
        if (adv) begin
            w_state_nx = trst_n ? tap_next(r_state, tms) : TEST_LOGIC_RESET;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TEST_LOGIC_RESET;
        end else begin
            r_state <= w_state_nx;
        end
    end

    assign tap_state = tap_onehot(r_state);

endmodule
`endif

// File: rtl/jtag_shift_engine.sv
// Batched JTAG master: shifts up to DATA_W TMS/TDI bits per command with a divided TCK
// and returns captured TDO. Optional TAP mirror output enabled by JTAG_TAP_TRACK_EN.
module jtag_shift_engine
    import jtag_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 16,
    parameter int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_tms,
    input  logic [DATA_W-1:0] cmd_tdi,
    input  logic              cmd_trst,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_tdo,
    output logic [LEN_W-1:0]  rsp_len,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    output logic              trst_n,
    input  logic              tdo,
    output logic              busy
`ifdef JTAG_TAP_TRACK_EN
    ,
    output logic [15:0]       tap_state
`endif
);

    fsm_e              r_state,  w_state_nx;
    logic [DIV_W-1:0]  r_cnt,    w_cnt_nx;
    logic [DIV_W-1:0]  r_div,    w_div_nx;
    logic [LEN_W-1:0]  r_len,    w_len_nx;
    logic [LEN_W-1:0]  r_idx,    w_idx_nx;
    logic [DATA_W-1:0] r_tms_sh, w_tms_sh_nx;
    logic [DATA_W-1:0] r_tdi_sh, w_tdi_sh_nx;
    logic [DATA_W-1:0] r_mask,   w_mask_nx;
    logic [DATA_W-1:0] r_cap,    w_cap_nx;
    logic              r_tck,    w_tck_nx;
    logic              r_tms,    w_tms_nx;
    logic              r_tdi,    w_tdi_nx;
    logic              r_trst_n, w_trst_n_nx;

    logic [LEN_W-1:0]  w_len_clamp;
    logic              w_half_done;
    logic              w_last_bit;

    assign w_len_clamp = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
    assign w_half_done = (r_cnt == r_div);
    assign w_last_bit  = (r_idx == (r_len - 1'b1));

    // Bits stream out of shift registers; r_mask marks where the next TDO sample lands
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_div_nx    = r_div;
        w_len_nx    = r_len;
        w_idx_nx    = r_idx;
        w_tms_sh_nx = r_tms_sh;
        w_tdi_sh_nx = r_tdi_sh;
        w_mask_nx   = r_mask;
        w_cap_nx    = r_cap;
        w_tck_nx    = r_tck;
        w_tms_nx    = r_tms;
        w_tdi_nx    = r_tdi;
        w_trst_n_nx = r_trst_n;

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_div_nx  = cfg_div;
                    w_len_nx  = w_len_clamp;
                    w_idx_nx  = '0;
                    w_cnt_nx  = '0;
                    w_cap_nx  = '0;
                    w_mask_nx = DATA_W'(1);
                    if (w_len_clamp == '0) begin
                        w_state_nx = RESP;
                    end else begin
                        w_state_nx  = LOW;
                        w_tck_nx    = 1'b0;
                        w_tms_nx    = cmd_tms[0];
                        w_tdi_nx    = cmd_tdi[0];
                        w_tms_sh_nx = cmd_tms >> 1;
                        w_tdi_sh_nx = cmd_tdi >> 1;
                        w_trst_n_nx = ~cmd_trst;
                    end
                end
            end
            LOW: begin
                if (w_half_done) begin
                    w_state_nx = HIGH;
                    w_cnt_nx   = '0;
                    w_tck_nx   = 1'b1;
                    if (tdo) begin
                        w_cap_nx = r_cap | r_mask;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (w_half_done) begin
                    w_cnt_nx = '0;
                    w_tck_nx = 1'b0;
                    if (w_last_bit) begin
                        w_state_nx  = RESP;
                        w_trst_n_nx = 1'b1;
                    end else begin
                        w_state_nx  = LOW;
                        w_idx_nx    = r_idx + 1'b1;
                        w_mask_nx   = r_mask << 1;
                        w_tms_nx    = r_tms_sh[0];
                        w_tdi_nx    = r_tdi_sh[0];
                        w_tms_sh_nx = r_tms_sh >> 1;
                        w_tdi_sh_nx = r_tdi_sh >> 1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                if (rsp_ready) begin
                    w_state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_div    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_tms_sh <= '0;
            r_tdi_sh <= '0;
            r_mask   <= '0;
            r_cap    <= '0;
            r_tck    <= 1'b0;
            r_tms    <= 1'b1;
            r_tdi    <= 1'b0;
            r_trst_n <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_div    <= w_div_nx;
            r_len    <= w_len_nx;
            r_idx    <= w_idx_nx;
            r_tms_sh <= w_tms_sh_nx;
            r_tdi_sh <= w_tdi_sh_nx;
            r_mask   <= w_mask_nx;
            r_cap    <= w_cap_nx;
            r_tck    <= w_tck_nx;
            r_tms    <= w_tms_nx;
            r_tdi    <= w_tdi_nx;
            r_trst_n <= w_trst_n_nx;
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_tdo   = r_cap;
    assign rsp_len   = r_len;
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign trst_n    = r_trst_n;

`ifdef JTAG_TAP_TRACK_EN
    logic w_adv;
    assign w_adv = (r_state == LOW) && w_half_done;

    jtag_tap_tracker u_tap_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (w_adv),
        .tms       (r_tms),
        .trst_n    (r_trst_n),
        .tap_state (tap_state)
    );
`endif

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Randomized bench for jtag_shift_engine with a cycle-arithmetic reference model
// and a few hand-computed expectations.
module tb_jtag_shift_engine;

    localparam int DATA_W = 32;
    localparam int DIV_W  = 16;
    localparam int LEN_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_tms = '0;
    logic [DATA_W-1:0] cmd_tdi = '0;
    logic              cmd_trst = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_tdo;
    logic [LEN_W-1:0]  rsp_len;
    logic              tck, tms, tdi, trst_n, busy;
    logic              tdo;
    logic              tdo_rnd = 1'b0;
    logic              loop = 1'b0;
`ifdef JTAG_TAP_TRACK_EN
    logic [15:0]       tap_state;
`endif

    assign tdo = loop ? tdi : tdo_rnd;

    jtag_shift_engine #(.DATA_W(DATA_W), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_div   (cfg_div),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_tms   (cmd_tms),
        .cmd_tdi   (cmd_tdi),
        .cmd_trst  (cmd_trst),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tdo   (rsp_tdo),
        .rsp_len   (rsp_len),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .trst_n    (trst_n),
        .tdo       (tdo),
        .busy      (busy)
`ifdef JTAG_TAP_TRACK_EN
        ,
        .tap_state (tap_state)
`endif
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tck_edges  = 0;
    int trst_edges = 0;

    initial forever begin
        @(posedge tck);
        tck_edges++;
        if (!trst_n) trst_edges++;
    end

    initial forever begin
        @(negedge clk);
        tdo_rnd = 1'($urandom);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h required=%h", name, $time, got, exp);
        end
    endtask

    // Reference model: m_k counts cycles since the accept edge; each bit spends
    // m_d cycles with tck low then m_d with tck high; response after 2*N*m_d cycles.
    logic        m_busy = 1'b0;
    int          m_k = 0;
    int          m_n = 0;
    int          m_d = 1;
    logic        m_trst = 1'b0;
    logic [31:0] m_tms = '0;
    logic [31:0] m_tdi = '0;
    logic [31:0] m_tdo = '0;
    logic        m_hold_tms = 1'b1;
    logic        m_hold_tdi = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_k        <= 0;
            m_n        <= 0;
            m_hold_tms <= 1'b1;
            m_hold_tdi <= 1'b0;
            m_tdo      <= '0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy <= 1'b1;
                m_k    <= 1;
                m_n    <= (int'(cmd_len) > DATA_W) ? DATA_W : int'(cmd_len);
                m_d    <= int'(cfg_div) + 1;
                m_tms  <= cmd_tms;
                m_tdi  <= cmd_tdi;
                m_trst <= cmd_trst;
                m_tdo  <= '0;
            end
        end else if (m_k > 2 * m_n * m_d) begin
            if (rsp_ready) begin
                m_busy <= 1'b0;
                if (m_n > 0) begin
                    m_hold_tms <= m_tms[m_n-1];
                    m_hold_tdi <= m_tdi[m_n-1];
                end
            end
        end else begin
            if (m_k >= m_d && ((m_k - m_d) % (2 * m_d)) == 0)
                m_tdo[(m_k - m_d) / (2 * m_d)] <= tdo;
            m_k <= m_k + 1;
        end
    end

    task automatic compare_cycle();
        logic [6:0] e;
        logic [6:0] g;
        int b;
        int ph;
        e = {1'b0, m_hold_tms, m_hold_tdi, 1'b1, 1'b1, 1'b0, 1'b0};
        if (m_busy) begin
            if (m_k <= 2 * m_n * m_d) begin
                b  = (m_k - 1) / (2 * m_d);
                ph = (m_k - 1) % (2 * m_d);
                e  = {(ph >= m_d), m_tms[b], m_tdi[b], ~m_trst, 1'b0, 1'b0, 1'b1};
            end else begin
                e = {1'b0, (m_n > 0) ? m_tms[m_n-1] : m_hold_tms,
                     (m_n > 0) ? m_tdi[m_n-1] : m_hold_tdi, 1'b1, 1'b0, 1'b1, 1'b1};
            end
        end
        g = {tck, tms, tdi, trst_n, cmd_ready, rsp_valid, busy};
        check("outputs{tck,tms,tdi,trst_n,cmd_ready,rsp_valid,busy}", 64'(g), 64'(e));
        if (m_busy && m_k > 2 * m_n * m_d) begin
            check("rsp_tdo", 64'(rsp_tdo), 64'(m_tdo));
            check("rsp_len", 64'(rsp_len), 64'(m_n));
        end
    endtask

    initial forever begin
        @(negedge clk);
        compare_cycle();
    end

    task automatic run_cmd(input int len, input logic [31:0] t_ms, input logic [31:0] t_di,
                           input logic trst, input int div, input int hold, input bit noise,
                           output int lat, output int edges,
                           output logic [31:0] tdo_got, output int len_got);
        int e0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cmd_tms   = t_ms;
        cmd_tdi   = t_di;
        cmd_trst  = trst;
        cfg_div   = DIV_W'(div);
        e0        = tck_edges;
        @(negedge clk);
        cmd_valid = 1'b0;
        cfg_div   = DIV_W'($urandom_range(0, 9));
        cmd_tms   = $urandom;
        cmd_tdi   = $urandom;
        cmd_len   = LEN_W'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20000) begin
            if (noise) begin
                cmd_valid = 1'($urandom);
                rsp_ready = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rsp_wait_bound", 64'(lat < 20000), 64'(1));
        edges   = tck_edges - e0;
        tdo_got = rsp_tdo;
        len_got = int'(rsp_len);
        repeat (hold) begin
            if (noise) cmd_valid = 1'($urandom);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, edges, lgot, e0, t0, n;
        logic [31:0] tgot;
        int len_r, div_r;

        repeat (3) @(negedge clk);
        check("reset_ctl{tck,tms,tdi,trst_n,rsp_valid,busy}",
              64'({tck, tms, tdi, trst_n, rsp_valid, busy}), 64'(6'b010100));
        check("reset_rsp_tdo", 64'(rsp_tdo), 64'(0));
        check("reset_rsp_len", 64'(rsp_len), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(cmd_ready), 64'(1));
`ifdef JTAG_TAP_TRACK_EN
        check("tap_reset", 64'(tap_state), 64'(16'h0001));
`endif

        run_cmd(5, 32'h1F, 32'h0, 1'b0, 0, 0, 1'b0, lat, edges, tgot, lgot);
        check("len5_div0_latency", 64'(lat), 64'(11));
        check("len5_div0_edges", 64'(edges), 64'(5));
`ifdef JTAG_TAP_TRACK_EN
        check("tap_after_tms_ones", 64'(tap_state), 64'(16'h0001));
`endif

        loop = 1'b1;
        run_cmd(8, $urandom, 32'hA5, 1'b0, 3, 0, 1'b0, lat, edges, tgot, lgot);
        loop = 1'b0;
        check("loopback_tdo", 64'(tgot), 64'(32'h0000_00A5));
        check("loopback_len", 64'(lgot), 64'(8));
        check("loopback_latency", 64'(lat), 64'(65));

        run_cmd(0, $urandom, $urandom, 1'b0, 2, 0, 1'b0, lat, edges, tgot, lgot);
        check("len0_latency", 64'(lat), 64'(1));
        check("len0_tdo", 64'(tgot), 64'(0));
        check("len0_edges", 64'(edges), 64'(0));

        run_cmd(40, $urandom, $urandom, 1'b0, 0, 0, 1'b0, lat, edges, tgot, lgot);
        check("len40_edges", 64'(edges), 64'(32));
        check("len40_rsp_len", 64'(lgot), 64'(32));
        check("len40_latency", 64'(lat), 64'(65));

        run_cmd(3, $urandom, $urandom, 1'b0, 1, 10, 1'b1, lat, edges, tgot, lgot);
        check("idle_after_held_rsp{busy,cmd_ready}", 64'({busy, cmd_ready}), 64'(2'b01));

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 6'd8; cmd_tms = $urandom; cmd_tdi = $urandom;
        cmd_trst = 1'b0; cfg_div = 16'd1;
        e0 = tck_edges;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while ((tck_edges - e0) < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("three_edges_seen", 64'(tck_edges - e0 >= 3), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctl{tck,tms,tdi,trst_n,rsp_valid,busy}",
              64'({tck, tms, tdi, trst_n, rsp_valid, busy}), 64'(6'b010100));
        check("async_reset_rsp_tdo", 64'(rsp_tdo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(4, $urandom, $urandom, 1'b0, 1, 0, 1'b0, lat, edges, tgot, lgot);
        check("post_reset_latency", 64'(lat), 64'(17));
        check("post_reset_edges", 64'(edges), 64'(4));

        t0 = trst_edges;
        run_cmd(6, $urandom, $urandom, 1'b1, 2, 1, 1'b0, lat, edges, tgot, lgot);
        check("trst_low_edges", 64'(trst_edges - t0), 64'(6));

        for (int i = 0; i < 40; i++) begin
            len_r = $urandom_range(0, 40);
            div_r = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3);
            loop  = 1'($urandom);
            run_cmd(len_r, $urandom, $urandom, ($urandom_range(0, 4) == 0), div_r,
                    $urandom_range(0, 3), 1'b1, lat, edges, tgot, lgot);
            check("rand_edges", 64'(edges), 64'((len_r > 32) ? 32 : len_r));
        end
        loop = 1'b0;

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
